// File: rtl/filter_pkg.sv
// Shared definitions for the Filter stream consumers.
//   FILTER_DATA_W : width of a Filter data word
//   filter_beat_t : one stream beat, sideband parity bit kept next to its data
package filter_pkg;

    localparam int FILTER_DATA_W = 16;

    typedef struct packed {
        logic                     parity;
        logic [FILTER_DATA_W-1:0] data;
    } filter_beat_t;

endpackage

// File: rtl/filter_rx_fifo_if.sv
// Stream bundle around filter_rx_fifo.
//   io_x_* : upstream beat (valid only, no ready: the source cannot stall)
//   io_y_* : downstream ready/valid beat
// Handshake: a beat moves on io_y_* at a rising clk edge exactly when
// io_y_valid and io_y_ready are both 1; io_y_valid never depends on io_y_ready,
// and io_y_data/io_y_parity hold steady while io_y_valid=1 and io_y_ready=0.
// Modports:
//   master : the environment (drives io_x_*, io_y_ready)
//   slave  : the FIFO        (drives io_y_data/valid/parity)
import filter_pkg::*;

interface filter_rx_fifo_if #(
    parameter int DATA_W = FILTER_DATA_W
);
    logic [DATA_W-1:0] io_x_data;
    logic              io_x_valid;
    logic              io_x_parity;
    logic [DATA_W-1:0] io_y_data;
    logic              io_y_valid;
    logic              io_y_parity;
    logic              io_y_ready;

    modport master (
        output io_x_data, io_x_valid, io_x_parity, io_y_ready,
        input  io_y_data, io_y_valid, io_y_parity
    );

    modport slave (
        input  io_x_data, io_x_valid, io_x_parity, io_y_ready,
        output io_y_data, io_y_valid, io_y_parity
    );
endinterface

// File: rtl/filter_fifo_mem.sv
// Register-array storage for filter_rx_fifo.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write word
//   raddr : read address (combinational read)
//   rdata : word at raddr
// Storage has no reset; the owner tracks which entries are valid.
import filter_pkg::*;

module filter_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = FILTER_DATA_W + 1,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/filter_rx_fifo.sv
// Receive FIFO for the Filter/FilterBlock output stream.
// The upstream has no backpressure, so every beat is buffered here and
// re-presented on a ready/valid port. A beat that finds the FIFO full (and no
// pop in the same cycle) is dropped and counted; stored beats are never touched.
//   clk         : clock, rising edge
//   reset       : asynchronous active-low reset
//   bus         : stream bundle (io_x_* in, io_y_* out)
//   io_count    : entries currently held
//   io_full     : io_count == DEPTH
//   io_overflow : sticky, set when any beat has been dropped
//   io_drops    : dropped-beat counter, saturating at all-ones
//   io_clr      : synchronous clear of io_overflow / io_drops
import filter_pkg::*;

module filter_rx_fifo #(
    parameter int DATA_W = FILTER_DATA_W,
    parameter int DEPTH  = 8,
    parameter int DROP_W = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    filter_rx_fifo_if.slave    bus,
    output logic [CNT_W-1:0]   io_count,
    output logic               io_full,
    output logic               io_overflow,
    output logic [DROP_W-1:0]  io_drops,
    input  logic               io_clr
);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic [DROP_W-1:0] drops;
    logic [DATA_W:0]   rd_word;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              drop;

    // Full/empty come from the count register so the pointers can simply wrap.
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    assign pop  = !empty && bus.io_y_ready;
    // A pop in the same cycle frees the slot the new beat needs.
    assign push = bus.io_x_valid && (!full || pop);
    assign drop = bus.io_x_valid && full && !pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // A drop in the same cycle as io_clr wins: the fresh drop is recorded
    // on top of a cleared counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            drops    <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (io_clr) begin
                drops <= DROP_W'(1);
            end else if (drops != '1) begin
                drops <= drops + DROP_W'(1);
            end
        end else if (io_clr) begin
            overflow <= 1'b0;
            drops    <= '0;
        end
    end

    filter_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({bus.io_x_parity, bus.io_x_data}),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );

    // Registered read pointer plus a write that lands on the edge gives the
    // one-cycle latency with no fall-through path.
    assign bus.io_y_valid  = !empty;
    assign bus.io_y_data   = rd_word[DATA_W-1:0];
    assign bus.io_y_parity = rd_word[DATA_W];

    assign io_count    = count;
    assign io_full     = full;
    assign io_overflow = overflow;
    assign io_drops    = drops;

endmodule
